// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync polarities and a span helper
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // True when pos lies in the inclusive range [lo, hi].
  function automatic logic in_span(input int unsigned pos, input int unsigned lo,
                                   input int unsigned hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider: one pix_ce pulse every CLK_DIV enabled cycles;
// held while en=0, cleared by clr.
module pix_ce_div #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK_50,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic pix_ce
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
    $error("pix_ce_div: CLK_DIV must be within 1..16");
  end

  logic [3:0] cnt;
  logic       ce_r;

  // Divider counter; the enable is registered and gated so en=0 forces it low at once.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 4'd0;
      ce_r <= 1'b0;
    end else if (clr) begin
      cnt  <= 4'd0;
      ce_r <= 1'b0;
    end else if (en) begin
      if (cnt == DIV_LAST) begin
        cnt  <= 4'd0;
        ce_r <= 1'b1;
      end else begin
        cnt  <= cnt + 4'd1;
        ce_r <= 1'b0;
      end
    end else begin
      cnt  <= cnt;
      ce_r <= ce_r;
    end
  end

  assign pix_ce = ce_r & en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered sync/blank/pulse outputs.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   X_DATA_WIDTH = 10,
  parameter int   Y_DATA_WIDTH = 10,
  parameter int   H_ACTIVE     = VGA_H_ACTIVE,
  parameter int   H_FP         = VGA_H_FP,
  parameter int   H_SYNC       = VGA_H_SYNC,
  parameter int   H_BP         = VGA_H_BP,
  parameter int   V_ACTIVE     = VGA_V_ACTIVE,
  parameter int   V_FP         = VGA_V_FP,
  parameter int   V_SYNC       = VGA_V_SYNC,
  parameter int   V_BP         = VGA_V_BP,
  parameter logic H_SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter logic V_SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV      = 2
) (
  input  logic                  CLK_50,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  resync,
  output logic                  pix_ce,
  output logic [X_DATA_WIDTH:0] x_pos,
  output logic [Y_DATA_WIDTH:0] y_pos,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank,
  output logic                  de,
  output logic                  line_start,
  output logic                  frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int XW      = X_DATA_WIDTH + 1;
  localparam int YW      = Y_DATA_WIDTH + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

  if (H_TOTAL > (1 << XW)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL does not fit x_pos");
  end
  if (V_TOTAL > (1 << YW)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL does not fit y_pos");
  end

  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          load;
  logic          hs_act;
  logic          vs_act;
  logic          active;

  pix_ce_div #(.CLK_DIV(CLK_DIV)) u_div (
    .CLK_50 (CLK_50),
    .reset_n(reset_n),
    .en     (en),
    .clr    (resync),
    .pix_ce (pix_ce)
  );

  // Next raster position; resync wins over a coincident wrap.
  always_comb begin
    x_nxt = x_pos;
    y_nxt = y_pos;
    load  = 1'b0;
    if (resync) begin
      x_nxt = {XW{1'b0}};
      y_nxt = {YW{1'b0}};
      load  = 1'b1;
    end else if (pix_ce) begin
      load = 1'b1;
      if (x_pos == X_LAST) begin
        x_nxt = {XW{1'b0}};
        y_nxt = (y_pos == Y_LAST) ? {YW{1'b0}} : y_pos + YW'(1);
      end else begin
        x_nxt = x_pos + XW'(1);
      end
    end else begin
      load = 1'b0;
    end
  end

  assign hs_act = in_span(32'(x_nxt), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
  assign vs_act = in_span(32'(y_nxt), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
  assign active = in_span(32'(x_nxt), 0, H_ACTIVE - 1) && in_span(32'(y_nxt), 0, V_ACTIVE - 1);

  // Position and decoded outputs are loaded together so they stay aligned.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      x_pos       <= {XW{1'b0}};
      y_pos       <= {YW{1'b0}};
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      blank       <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (load) begin
      x_pos       <= x_nxt;
      y_pos       <= y_nxt;
      hsync       <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vsync       <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      blank       <= ~active;
      de          <= active;
      line_start  <= (x_nxt == {XW{1'b0}});
      frame_start <= (x_nxt == {XW{1'b0}}) && (y_nxt == {YW{1'b0}});
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Free-running frame count; neither en nor resync clears it.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= 16'd0;
    end else if (load && (x_nxt == {XW{1'b0}}) && (y_nxt == {YW{1'b0}})) begin
      frame_cnt <= frame_cnt + 16'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed, table-driven bench for vga_timing_gen: default 640x480 timing,
// CLK_DIV=1/3 variants and a tiny raster for frame wrap and resync corners.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic resync = 1'b0;

  always #5 clk = ~clk;

  logic        d_pce, d_hs, d_vs, d_bl, d_de, d_ls, d_fs;
  logic [10:0] d_x, d_y;
  logic        o_pce, o_hs, o_vs, o_bl, o_de, o_ls, o_fs;
  logic [10:0] o_x, o_y;
  logic        t_pce, t_hs, t_vs, t_bl, t_de, t_ls, t_fs;
  logic [10:0] t_x, t_y;
  logic        s_pce, s_hs, s_vs, s_bl, s_de, s_ls, s_fs;
  logic [10:0] s_x, s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] d_fc, o_fc, t_fc, s_fc;
`endif

  vga_timing_gen dut (
    .CLK_50(clk), .reset_n(reset_n), .en(en), .resync(resync), .pix_ce(d_pce),
    .x_pos(d_x), .y_pos(d_y), .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(1)) dut1 (
    .CLK_50(clk), .reset_n(reset_n), .en(en), .resync(resync), .pix_ce(o_pce),
    .x_pos(o_x), .y_pos(o_y), .hsync(o_hs), .vsync(o_vs), .blank(o_bl), .de(o_de),
    .line_start(o_ls), .frame_start(o_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(o_fc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(3)) dut3 (
    .CLK_50(clk), .reset_n(reset_n), .en(en), .resync(resync), .pix_ce(t_pce),
    .x_pos(t_x), .y_pos(t_y), .hsync(t_hs), .vsync(t_vs), .blank(t_bl), .de(t_de),
    .line_start(t_ls), .frame_start(t_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(t_fc)
`endif
  );

  // Tiny raster: 15 pixels x 8 lines, hsync at x=10..12, vsync at y=5..6.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1)
  ) dut_s (
    .CLK_50(clk), .reset_n(reset_n), .en(en), .resync(resync), .pix_ce(s_pce),
    .x_pos(s_x), .y_pos(s_y), .hsync(s_hs), .vsync(s_vs), .blank(s_bl), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int kcur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    kcur++;
  endtask

  typedef struct {
    int n; int x; int y; int hs; int bl; int pce; int ls; int x1;
  } tv_t;

  typedef struct {
    int k; int x; int y; int hs; int vs; int ls; int fs;
  } sv_t;

  tv_t tv[11];
  sv_t sv[9];
  logic found;

  initial begin
    // Default raster, CLK_DIV=2: x = (N-1)/2 after enabled edge N.
    tv[0]  = '{2,    0,   0, 1, 0, 1, 0, 1};
    tv[1]  = '{3,    1,   0, 1, 0, 0, 0, 2};
    tv[2]  = '{1279, 639, 0, 1, 0, 0, 0, 478};
    tv[3]  = '{1281, 640, 0, 1, 1, 0, 0, 480};
    tv[4]  = '{1311, 655, 0, 1, 1, 0, 0, 510};
    tv[5]  = '{1313, 656, 0, 0, 1, 0, 0, 512};
    tv[6]  = '{1503, 751, 0, 0, 1, 0, 0, 702};
    tv[7]  = '{1505, 752, 0, 1, 1, 0, 0, 704};
    tv[8]  = '{1599, 799, 0, 1, 1, 0, 0, 798};
    tv[9]  = '{1601, 0,   1, 1, 0, 0, 1, 0};
    tv[10] = '{1602, 0,   1, 1, 0, 1, 0, 1};

    // Tiny raster, k edges after a resync: pixel index k-1.
    sv[0] = '{12,  11, 0, 0, 1, 0, 0};
    sv[1] = '{14,  13, 0, 1, 1, 0, 0};
    sv[2] = '{61,  0,  4, 1, 1, 1, 0};
    sv[3] = '{76,  0,  5, 1, 0, 1, 0};
    sv[4] = '{91,  0,  6, 1, 0, 1, 0};
    sv[5] = '{106, 0,  7, 1, 1, 1, 0};
    sv[6] = '{120, 14, 7, 1, 1, 0, 0};
    sv[7] = '{121, 0,  0, 1, 1, 1, 1};
    sv[8] = '{122, 1,  0, 1, 1, 0, 0};

    #1 reset_n = 1'b0;
    #2;
    chk("rst_x", d_x, 0);        chk("rst_y", d_y, 0);
    chk("rst_hsync", d_hs, 1);   chk("rst_vsync", d_vs, 1);
    chk("rst_blank", d_bl, 0);   chk("rst_de", d_de, 1);
    chk("rst_ls", d_ls, 0);      chk("rst_fs", d_fs, 0);
    chk("rst_pce", d_pce, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b1;
    reset_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < 11; i++) begin
      while (cyc < tv[i].n) tick();
      chk($sformatf("x@%0d", tv[i].n), d_x, tv[i].x);
      chk($sformatf("y@%0d", tv[i].n), d_y, tv[i].y);
      chk($sformatf("hsync@%0d", tv[i].n), d_hs, tv[i].hs);
      chk($sformatf("blank@%0d", tv[i].n), d_bl, tv[i].bl);
      chk($sformatf("de@%0d", tv[i].n), d_de, 1 - tv[i].bl);
      chk($sformatf("pce@%0d", tv[i].n), d_pce, tv[i].pce);
      chk($sformatf("ls@%0d", tv[i].n), d_ls, tv[i].ls);
      chk($sformatf("div1_x@%0d", tv[i].n), o_x, tv[i].x1);
      chk($sformatf("div1_pce@%0d", tv[i].n), o_pce, 1);
      chk($sformatf("div3_pce@%0d", tv[i].n), t_pce, (tv[i].n % 3 == 0) ? 1 : 0);
    end

    // Pause at x=100 for 10 cycles, then resume.
    while (cyc < 1801) tick();
    chk("pause_x_before", d_x, 100);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_x_hold", d_x, 100);
      chk("pause_pce_low", d_pce, 0);
    end
    en = 1'b1;
    tick();
    chk("resume_pce", d_pce, 1);
    chk("resume_x_still", d_x, 100);
    tick();
    chk("resume_x_next", d_x, 101);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (d_x == 11'd300) found = 1'b1;
      else tick();
    end
    chk("wait_x300", found, 1);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    kcur = 0;
    chk("resync_x", d_x, 0);     chk("resync_y", d_y, 0);
    chk("resync_fs", d_fs, 1);   chk("resync_ls", d_ls, 1);
    chk("resync_pce", d_pce, 0);
    chk("resync_s_x", s_x, 0);   chk("resync_s_fs", s_fs, 1);
    tick();
    chk("resync_fs_drop", d_fs, 0);
    chk("resync_ls_drop", d_ls, 0);

    for (int i = 0; i < 9; i++) begin
      while (kcur < sv[i].k) tick();
      chk($sformatf("s_x@k%0d", sv[i].k), s_x, sv[i].x);
      chk($sformatf("s_y@k%0d", sv[i].k), s_y, sv[i].y);
      chk($sformatf("s_hsync@k%0d", sv[i].k), s_hs, sv[i].hs);
      chk($sformatf("s_vsync@k%0d", sv[i].k), s_vs, sv[i].vs);
      chk($sformatf("s_ls@k%0d", sv[i].k), s_ls, sv[i].ls);
      chk($sformatf("s_fs@k%0d", sv[i].k), s_fs, sv[i].fs);
    end

    // Resync landing on the frame-wrap edge: one pulse only.
    resync = 1'b1;
    tick();
    resync = 1'b0;
    kcur = 0;
    while (kcur < 120) tick();
    chk("wrap_pre_x", s_x, 14);
    chk("wrap_pre_y", s_y, 7);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("wrap_rs_x", s_x, 0);   chk("wrap_rs_y", s_y, 0);
    chk("wrap_rs_fs", s_fs, 1); chk("wrap_rs_ls", s_ls, 1);
    tick();
    chk("wrap_rs_fs_once", s_fs, 0);
    chk("wrap_rs_ls_once", s_ls, 0);
    chk("wrap_rs_x_hold", s_x, 0);

    // Asynchronous reset mid-line, checked before the next clock edge.
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    #2;
    chk("async_x", d_x, 0);      chk("async_y", d_y, 0);
    chk("async_hsync", d_hs, 1); chk("async_vsync", d_vs, 1);
    chk("async_blank", d_bl, 0); chk("async_de", d_de, 1);
    chk("async_ls", d_ls, 0);    chk("async_fs", d_fs, 0);
    chk("async_pce", d_pce, 0);  chk("async_s_x", s_x, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0;
    tick();
    chk("rel_pce_e1", d_pce, 0);
    chk("rel_div3_e1", t_pce, 0);
    tick();
    chk("rel_pce_e2", d_pce, 1);
    chk("rel_x_e2", d_x, 0);
    tick();
    chk("rel_x_e3", d_x, 1);
    chk("rel_div3_e3", t_pce, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
